// File: rtl/gameboy_types_pkg.sv
// Types shared across the Game Boy core: clock phases, interrupt sources and
// the interrupt dispatch sequencer states.
package gameboy_types_pkg;
    localparam int NUM_INT_SOURCES = 5;

    typedef enum logic [1:0] {T1, T2, T3, T4} t_phase_t;

    typedef enum logic [2:0] {
        INT_VBLANK = 3'd0,
        INT_STAT,
        INT_TIMER,
        INT_SERIAL,
        INT_JOYPAD
    } int_source_e;

    typedef enum logic [1:0] {IDLE, ARMED, RESOLVE, DONE} int_fsm_e;
endpackage

// File: rtl/mmu_addresses_pkg.sv
// Memory-mapped register addresses decoded by the peripherals.
package mmu_addresses_pkg;
    localparam logic [15:0] IF_ADDR_C = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_C = 16'hFFFF;
endpackage

// File: rtl/bus_if.sv
// Peripheral bus shared by the memory-mapped blocks; reads are combinational.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        write_en;
    logic        read_en;
    logic [7:0]  rdata;

    modport Peripheral_side (input addr, wdata, write_en, read_en, output rdata);
    modport Cpu_side        (output addr, wdata, write_en, read_en, input rdata);
endinterface

// File: rtl/int_priority_encoder.sv
// Picks the lowest-numbered active interrupt and its one-hot clear mask.
module int_priority_encoder
    import gameboy_types_pkg::*;
(
    input  logic [NUM_INT_SOURCES-1:0] mask_i,
    output logic                       found_o,
    output logic [2:0]                 index_o,
    output logic [NUM_INT_SOURCES-1:0] clear_o
);
    always_comb begin
        found_o = 1'b0;
        index_o = 3'd0;
        clear_o = '0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int n = NUM_INT_SOURCES - 1; n >= 0; n--) begin
            if (mask_i[n]) begin
                found_o    = 1'b1;
                index_o    = 3'(n);
                clear_o    = '0;
                clear_o[n] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register owner and CPU interrupt dispatch sequencer
// (start -> sample -> resolve -> done).
module interrupt_controller
    import gameboy_types_pkg::*;
    import mmu_addresses_pkg::*;
#(
    parameter logic [15:0] IF_ADDR     = IF_ADDR_C,
    parameter logic [15:0] IE_ADDR     = IE_ADDR_C,
    parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  t_phase_t                   t_phase,
    Bus_if.Peripheral_side             bus,
    input  logic [NUM_INT_SOURCES-1:0] req,
    input  logic                       ime,
    output logic                       int_pending,
    output logic                       int_req,
    input  logic                       disp_start,
    input  logic                       disp_sample,
    output logic [15:0]                int_vector,
    output logic                       int_busy
);
    logic [NUM_INT_SOURCES-1:0] if_q, if_d;
    logic [7:0]                 ie_q, ie_d;
    int_fsm_e                   state_q, state_d;
    logic                       pend_q, pend_d;
    logic                       req_q, req_d;
    logic [15:0]                vec_q, vec_d;

    logic                       found;
    logic [2:0]                 idx;
    logic [NUM_INT_SOURCES-1:0] clr;
    logic                       is_t4, wr_if, wr_ie, ack;

    assign is_t4 = (t_phase == T4);
    assign wr_if = bus.write_en && (bus.addr == IF_ADDR);
    assign wr_ie = bus.write_en && (bus.addr == IE_ADDR);

    int_priority_encoder u_enc (
        .mask_i  (ie_q[NUM_INT_SOURCES-1:0] & if_q),
        .found_o (found),
        .index_o (idx),
        .clear_o (clr)
    );

    always_comb begin
        bus.rdata = 8'hFF;
        if (bus.read_en) begin
            if (bus.addr == IF_ADDR)      bus.rdata = {3'b111, if_q};
            else if (bus.addr == IE_ADDR) bus.rdata = ie_q;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack     = 1'b0;
        case (state_q)
            IDLE:    if (disp_start) state_d = ARMED;
            ARMED: begin
                if (disp_sample) begin
                    state_d = RESOLVE;
                    if (found) begin
                        ack   = 1'b1;
                        vec_d = VECTOR_BASE + {10'd0, idx, 3'b000};
                    end else begin
                        vec_d = 16'h0000;
                    end
                end
            end
            RESOLVE: state_d = DONE;
            DONE:    if (is_t4) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-bit precedence: a new request beats the dispatch ack, which beats a bus write.
    always_comb begin
        if_d = if_q;
        if (wr_if) if_d = bus.wdata[NUM_INT_SOURCES-1:0];
        if (ack)   if_d = if_d & ~clr;
        if_d = if_d | req;

        ie_d   = wr_ie ? bus.wdata : ie_q;
        pend_d = is_t4 ? found : pend_q;
        if (state_d != IDLE) req_d = 1'b0;
        else if (is_t4)      req_d = found & ime;
        else                 req_d = req_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_q    <= 5'h01;
            ie_q    <= 8'h00;
            state_q <= IDLE;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            vec_q   <= 16'h0000;
        end else begin
            if_q    <= if_d;
            ie_q    <= ie_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
        end
    end

    assign int_pending = pend_q;
    assign int_req     = req_q;
    assign int_vector  = vec_q;
    assign int_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a behavioural model.
module tb_interrupt_controller;
    import gameboy_types_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    t_phase_t    tphase;
    logic [4:0]  req;
    logic        ime, disp_start, disp_sample;
    logic        int_pending, int_req, int_busy;
    logic [15:0] int_vector;
    Bus_if       bus_if_i ();

    interrupt_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t_phase     (tphase),
        .bus         (bus_if_i),
        .req         (req),
        .ime         (ime),
        .int_pending (int_pending),
        .int_req     (int_req),
        .disp_start  (disp_start),
        .disp_sample (disp_sample),
        .int_vector  (int_vector),
        .int_busy    (int_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ph       = 0;

    // Behavioural model state
    int m_if, m_ie, m_vec, m_edges, m_samp_edge;
    bit m_pend, m_req, m_busy, m_sampled;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus_if_i.addr    = a;
        bus_if_i.read_en = 1'b1;
        #1;
        d = bus_if_i.rdata;
        bus_if_i.read_en = 1'b0;
    endtask

    task automatic model_reset();
        m_if = 'h01; m_ie = 0; m_vec = 0; m_edges = 0; m_samp_edge = 0;
        m_pend = 0; m_req = 0; m_busy = 0; m_sampled = 0;
    endtask

    task automatic model_edge(input int p);
        int live, pick, new_if;
        live   = m_if & m_ie & 'h1F;
        pick   = -1;
        new_if = m_if;
        for (int n = 4; n >= 0; n--) if (((live >> n) & 1) == 1) pick = n;
        if (bus_if_i.write_en && bus_if_i.addr == 16'hFF0F) new_if = int'(bus_if_i.wdata) & 'h1F;
        if (bus_if_i.write_en && bus_if_i.addr == 16'hFFFF) m_ie = int'(bus_if_i.wdata);
        if (!m_busy) begin
            if (disp_start) begin m_busy = 1; m_sampled = 0; end
        end else if (!m_sampled) begin
            if (disp_sample) begin
                m_sampled   = 1;
                m_samp_edge = m_edges;
                if (pick >= 0) begin
                    m_vec  = 'h40 + 8 * pick;
                    new_if = new_if & ~(1 << pick);
                end else begin
                    m_vec = 0;
                end
            end
        end else if (m_edges >= m_samp_edge + 2 && p == 3) begin
            m_busy = 0;
        end
        new_if = new_if | int'(req);
        if (p == 3) m_pend = (live != 0);
        if (m_busy)      m_req = 0;
        else if (p == 3) m_req = m_pend && ime;
        m_if = new_if;
        m_edges++;
    endtask

    task automatic check_all();
        logic [7:0] d;
        rd(16'hFF0F, d); check_eq("if_rd", {8'h00, d}, 16'(32'hE0 | m_if));
        rd(16'hFFFF, d); check_eq("ie_rd", {8'h00, d}, 16'(m_ie));
        rd(16'hFF10, d); check_eq("other_rd", {8'h00, d}, 16'h00FF);
        check_eq("int_pending", {15'd0, int_pending}, {15'd0, m_pend});
        check_eq("int_req", {15'd0, int_req}, {15'd0, m_req});
        check_eq("int_busy", {15'd0, int_busy}, {15'd0, m_busy});
        check_eq("int_vector", int_vector, 16'(m_vec));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(ph);
        #1;
        req = '0; disp_start = 0; disp_sample = 0; bus_if_i.write_en = 0;
        ph = (ph + 1) % 4;
        tphase = t_phase_t'(ph);
        check_all();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_if_i.addr = a; bus_if_i.wdata = d; bus_if_i.write_en = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (int_req !== 1'b1 && k < 8) begin tick(); k++; end
        check_eq(tag, {15'd0, int_req}, 16'h0001);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (int_busy !== 1'b0 && k < 8) begin tick(); k++; end
        check_eq(tag, {15'd0, int_busy}, 16'h0000);
    endtask

    task automatic dispatch(input string tag, input logic [15:0] vec, input logic [7:0] ifv);
        logic [7:0] d;
        disp_start = 1; tick();
        tick();
        disp_sample = 1; tick();
        check_eq({tag, "_vec"}, int_vector, vec);
        rd(16'hFF0F, d); check_eq({tag, "_if"}, {8'h00, d}, {8'h00, ifv});
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        logic [7:0] d;
        reset_n = 0; tphase = T1; req = '0; ime = 0;
        disp_start = 0; disp_sample = 0;
        bus_if_i.addr = '0; bus_if_i.wdata = '0;
        bus_if_i.write_en = 0; bus_if_i.read_en = 0;
        model_reset();
        #12 reset_n = 1;

        // 1: reset state
        rd(16'hFF0F, d); check_eq("t1_if", {8'h00, d}, 16'h00E1);
        rd(16'hFFFF, d); check_eq("t1_ie", {8'h00, d}, 16'h0000);
        check_eq("t1_req", {15'd0, int_req}, 16'h0000);

        // 2: timer interrupt
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h04);
        ime = 1; req = 5'b00100; tick();
        wait_req("t2_req");
        dispatch("t2", 16'h0050, 8'hE0);

        // 3: two simultaneous requests, serviced by priority
        wr(16'hFFFF, 8'h1F);
        req = 5'b10010; tick();
        wait_req("t3_req");
        dispatch("t3a", 16'h0048, 8'hF0);
        wait_req("t3_req2");
        dispatch("t3b", 16'h0060, 8'hE0);

        // 4: IE cleared mid-dispatch
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        disp_start = 1; tick();
        wr(16'hFFFF, 8'h00);
        disp_sample = 1; tick();
        check_eq("t4_vec", int_vector, 16'h0000);
        rd(16'hFF0F, d); check_eq("t4_if", {8'h00, d}, 16'h00E1);
        wait_idle("t4_idle");

        // 5: request beats a clearing write
        ime = 0;
        wr(16'hFFFF, 8'h04);
        bus_if_i.addr = 16'hFF0F; bus_if_i.wdata = 8'h00; bus_if_i.write_en = 1;
        req = 5'b00100; tick();
        rd(16'hFF0F, d); check_eq("t5_if", {8'h00, d}, 16'h00E4);
        repeat (5) tick();
        check_eq("t5_pend", {15'd0, int_pending}, 16'h0001);
        check_eq("t5_req", {15'd0, int_req}, 16'h0000);

        // 6: async reset while ARMED
        ime = 1;
        dispatch("t6pre", 16'h0050, 8'hE0);
        disp_start = 1; tick();
        #1 reset_n = 0;
        model_reset();
        #1;
        check_eq("t6_busy", {15'd0, int_busy}, 16'h0000);
        check_eq("t6_vec", int_vector, 16'h0000);
        check_eq("t6_pend", {15'd0, int_pending}, 16'h0000);
        rd(16'hFF0F, d); check_eq("t6_if", {8'h00, d}, 16'h00E1);
        #1 reset_n = 1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req         = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            ime         = ($urandom_range(0, 7) != 0);
            disp_start  = ($urandom_range(0, 5) == 0);
            disp_sample = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bus_if_i.addr = 16'hFF0F;
                    1:       bus_if_i.addr = 16'hFFFF;
                    default: bus_if_i.addr = 16'hFF10;
                endcase
                bus_if_i.wdata    = 8'($urandom);
                bus_if_i.write_en = 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
